// File: rtl/fixed_pkg.sv
// Fixed-point types shared across the datapath, plus the RSI window scheduler FSM encoding.
package fixed_pkg;

    localparam int FIXED_FRAC_BITS   = 8;
    localparam int UQ16_16_FRAC_BITS = 16;

    typedef logic [15:0] uq8_8_t;
    typedef logic [31:0] uq16_16_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_G = 3'd1,
        ISSUE_L = 3'd2,
        WAIT    = 3'd3,
        OUT     = 3'd4,
        DRAIN   = 3'd5
    } rsi_sched_state_t;

    // Re-scale an integer-valued sum of uq8_8 samples into uq16_16.
    function automatic uq16_16_t widen_uq8_8_sum(input logic [31:0] s);
        return s << (UQ16_16_FRAC_BITS - FIXED_FRAC_BITS);
    endfunction

endpackage

// File: rtl/tree_adder_14.sv
// Pipelined N-input adder: sums N unsigned W-bit lanes, result and valid appear LAT cycles later.
module tree_adder_14 #(
    parameter int N          = 14,
    parameter int W          = 16,
    parameter int LAT        = 4,
    parameter bit G_POLARITY = 1'b1,
    localparam int SW        = W + $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [N*W-1:0]  i_data,
    output logic            o_valid,
    output logic [SW-1:0]   o_sum
);

    logic          rst_act;
    logic [SW-1:0] sum_c;
    logic [LAT-1:0] vld_q;
    logic [SW-1:0] sum_q [LAT];

    assign rst_act = (i_rst == G_POLARITY);

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + SW'(i_data[i*W +: W]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst_act) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= i_valid;
            sum_q[0] <= sum_c;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                sum_q[i] <= sum_q[i-1];
            end
        end
    end

    assign o_valid = vld_q[LAT-1];
    assign o_sum   = sum_q[LAT-1];

endmodule

// File: rtl/rsi_window_sched.sv
// RSI gain/loss window scheduler: one shared tree adder sums the gain ring, then the loss ring.
// Build option RSI_SCHED_WARMUP_EN suppresses sums until the window holds N_WINDOW diffs.
module rsi_window_sched
    import fixed_pkg::*;
#(
    parameter int N_WINDOW  = 14,
    parameter int ADDER_LAT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  uq8_8_t                        i_price,
    input  logic                          i_price_valid,
    output logic                          o_price_ready,
    output uq16_16_t                      o_gain_sum,
    output uq16_16_t                      o_loss_sum,
    output logic                          o_sum_valid,
    input  logic                          i_sum_ready,
    output logic [$clog2(N_WINDOW+1)-1:0] o_fill,
    output rsi_sched_state_t              o_state
);

    localparam int FILL_W  = $clog2(N_WINDOW + 1);
    localparam int PTR_W   = $clog2(N_WINDOW);
    localparam int SUM_W   = 16 + $clog2(N_WINDOW);
    localparam int DRAIN_W = $clog2(ADDER_LAT + 2);

    rsi_sched_state_t state_q, state_d;

    uq8_8_t              gain_ring [N_WINDOW];
    uq8_8_t              loss_ring [N_WINDOW];
    uq8_8_t              prev_q;
    logic                prev_valid_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [FILL_W-1:0]   fill_q;
    uq16_16_t            gain_sum_q, loss_sum_q;
    logic                got_gain_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;

    logic                accept, do_write, warm_skip;
    logic                adder_valid, adder_sel_loss;
    logic [N_WINDOW*16-1:0] adder_data;
    logic                adder_o_valid;
    logic [SUM_W-1:0]    adder_sum;
    uq8_8_t              gain_w, loss_w;

    // Both handshakes are plain valid/ready: a transfer happens on a rising edge where valid and
    // ready are both high; the producer holds its data steady until that edge.
    assign accept   = o_price_ready & i_price_valid;
    assign do_write = accept & prev_valid_q;
    assign gain_w   = (i_price > prev_q) ? (i_price - prev_q) : '0;
    assign loss_w   = (prev_q > i_price) ? (prev_q - i_price) : '0;

`ifdef RSI_SCHED_WARMUP_EN
    assign warm_skip = (fill_q < FILL_W'(N_WINDOW - 1));
`else
    assign warm_skip = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = DRAIN;
        end else begin
            case (state_q)
                IDLE:    if (do_write && !warm_skip) state_d = ISSUE_G;
                ISSUE_G: state_d = ISSUE_L;
                ISSUE_L: state_d = WAIT;
                WAIT:    if (adder_o_valid && got_gain_q) state_d = OUT;
                OUT:     if (i_sum_ready) state_d = IDLE;
                DRAIN:   if (drain_cnt_q == DRAIN_W'(ADDER_LAT)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_price_ready  = (state_q == IDLE) && !i_flush;
        o_sum_valid    = (state_q == OUT);
        adder_valid    = (state_q == ISSUE_G) || (state_q == ISSUE_L);
        adder_sel_loss = (state_q == ISSUE_L);
    end

    always_comb begin
        adder_data = '0;
        for (int i = 0; i < N_WINDOW; i++) begin
            adder_data[i*16 +: 16] = adder_sel_loss ? loss_ring[i] : gain_ring[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_WINDOW; i++) begin
                gain_ring[i] <= '0;
                loss_ring[i] <= '0;
            end
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            gain_sum_q   <= '0;
            loss_sum_q   <= '0;
            got_gain_q   <= 1'b0;
            drain_cnt_q  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < N_WINDOW; i++) begin
                gain_ring[i] <= '0;
                loss_ring[i] <= '0;
            end
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            got_gain_q   <= 1'b0;
            drain_cnt_q  <= '0;
        end else begin
            if (accept) begin
                prev_q       <= i_price;
                prev_valid_q <= 1'b1;
                if (prev_valid_q) begin
                    gain_ring[wr_ptr_q] <= gain_w;
                    loss_ring[wr_ptr_q] <= loss_w;
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(N_WINDOW - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                    if (fill_q != FILL_W'(N_WINDOW)) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
            end
            // Results arriving outside ISSUE_L/WAIT belong to a flushed request and are dropped.
            if ((state_q == ISSUE_L || state_q == WAIT) && adder_o_valid) begin
                if (!got_gain_q) begin
                    gain_sum_q <= widen_uq8_8_sum(32'(adder_sum));
                    got_gain_q <= 1'b1;
                end else begin
                    loss_sum_q <= widen_uq8_8_sum(32'(adder_sum));
                end
            end
            if (state_q == OUT && i_sum_ready) begin
                got_gain_q <= 1'b0;
            end
            if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end
        end
    end

    tree_adder_14 #(
        .N          (N_WINDOW),
        .W          (16),
        .LAT        (ADDER_LAT),
        .G_POLARITY (1'b1)
    ) u_adder (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (adder_valid),
        .i_data  (adder_data),
        .o_valid (adder_o_valid),
        .o_sum   (adder_sum)
    );

    assign o_gain_sum = gain_sum_q;
    assign o_loss_sum = loss_sum_q;
    assign o_fill     = fill_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_rsi_window_sched.sv
// Bench for rsi_window_sched: directed scenarios plus random prices/flushes against a queue-based window model.
module tb_rsi_window_sched;
    import fixed_pkg::*;

    localparam int N   = 14;
    localparam int LAT = 4;
    localparam int FW  = $clog2(N + 1);
    localparam int EW  = 64 + FW;
`ifdef RSI_SCHED_WARMUP_EN
    localparam bit WARM = 1'b1;
`else
    localparam bit WARM = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_flush = 1'b0;
    uq8_8_t           i_price = '0;
    logic             i_price_valid = 1'b0;
    logic             i_sum_ready = 1'b1;
    logic             o_price_ready, o_sum_valid;
    uq16_16_t         o_gain_sum, o_loss_sum;
    logic [FW-1:0]    o_fill;
    rsi_sched_state_t o_state;

    always #5 i_clk = ~i_clk;

    rsi_window_sched #(.N_WINDOW(N), .ADDER_LAT(LAT)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_price       (i_price),
        .i_price_valid (i_price_valid),
        .o_price_ready (o_price_ready),
        .o_gain_sum    (o_gain_sum),
        .o_loss_sum    (o_loss_sum),
        .o_sum_valid   (o_sum_valid),
        .i_sum_ready   (i_sum_ready),
        .o_fill        (o_fill),
        .o_state       (o_state)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_acc = 0;
    int t_rise = -1;
    int n_res = 0;
    int ready_mode = 0;
    logic sv_d = 1'b0;
    logic [31:0] last_g = '0, last_l = '0;
    logic [FW-1:0] last_f = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int m_g[$];
    int m_l[$];
    int m_prev = 0;
    bit m_prev_valid = 0;

    task automatic model_clear();
        m_g.delete();
        m_l.delete();
        m_prev_valid = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int p);
        int sg, sl;
        if (!m_prev_valid) begin
            m_prev = p;
            m_prev_valid = 1;
            return;
        end
        m_g.push_back(p > m_prev ? p - m_prev : 0);
        m_l.push_back(m_prev > p ? m_prev - p : 0);
        m_prev = p;
        if (m_g.size() > N) begin
            void'(m_g.pop_front());
            void'(m_l.pop_front());
        end
        sg = 0;
        sl = 0;
        foreach (m_g[i]) begin
            sg += m_g[i];
            sl += m_l[i];
        end
        if (!WARM || m_g.size() == N)
            exp_q.push_back({32'(sg * 256), 32'(sl * 256), FW'(m_g.size())});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst && o_sum_valid && !sv_d) t_rise = cyc;
        sv_d = o_sum_valid & ~i_rst;
        if (!i_rst && !i_flush && o_sum_valid && i_sum_ready) begin
            n_res++;
            last_g = o_gain_sum;
            last_l = o_loss_sum;
            last_f = o_fill;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_sum: got gain 0x%0h loss 0x%0h while no result was expected", o_gain_sum, o_loss_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("gain_sum", o_gain_sum, mon_e[EW-1 -: 32]);
                chk("loss_sum", o_loss_sum, mon_e[FW+31 -: 32]);
                chk("fill_at_out", o_fill, mon_e[FW-1:0]);
            end
        end
    end

    // ---------------- consumer ready driver ----------------
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_sum_ready = 1'b1;
            1:       i_sum_ready = 1'($urandom_range(0, 1));
            default: i_sum_ready = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_price(input int p);
        int n = 0;
        bit done = 0;
        i_price = uq8_8_t'(p);
        i_price_valid = 1'b1;
        while (!done) begin
            @(negedge i_clk);
            if (o_price_ready) begin
                model_accept(p);
                t_acc = cyc;
                done = 1;
            end else if (++n > 300) begin
                n_chk++;
                n_err++;
                $display("FAIL accept_timeout: price 0x%0h not accepted within 300 cycles", p);
                done = 1;
            end
            tick();
        end
        i_price_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        bit ok = 0;
        while (!ok && n < 300) begin
            @(negedge i_clk);
            n++;
            ok = (exp_q.size() == 0) && o_price_ready;
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d results still pending after 300 cycles", exp_q.size());
        end
        tick();
    endtask

    task automatic do_flush(input bit with_price);
        i_flush = 1'b1;
        if (with_price) begin
            i_price = uq8_8_t'($urandom_range(0, 65535));
            i_price_valid = 1'b1;
        end
        model_clear();
        @(negedge i_clk);
        if (with_price) chk("ready_during_flush", o_price_ready, 0);
        tick();
        i_flush = 1'b0;
        i_price_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int n_before;
        model_clear();
        repeat (3) tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_sum_valid", o_sum_valid, 0);
        chk("rst_fill", o_fill, 0);
        chk("rst_price_ready", o_price_ready, 1);
        chk("rst_gain", o_gain_sum, 0);
        chk("rst_loss", o_loss_sum, 0);
        tick();

        // Rising ramp 100.0 .. 114.0
        ready_mode = 0;
        for (int k = 0; k < 14; k++) begin
            send_price((100 + k) << 8);
            wait_done();
        end
        send_price(114 << 8);
        acc = t_acc;
        wait_done();
        chk("latency", 64'(t_rise - acc), LAT + 3);
`ifdef RSI_SCHED_WARMUP_EN
        chk("n_results_ramp", n_res, 1);
`else
        chk("n_results_ramp", n_res, 14);
`endif
        chk("ramp_gain", last_g, 32'h000E0000);
        chk("ramp_loss", last_l, 0);
        chk("ramp_fill", last_f, N);

        // Down-tick overwrites the oldest slot
        send_price(113 << 8);
        wait_done();
        chk("wrap_gain", last_g, 32'h000D0000);
        chk("wrap_loss", last_l, 32'h00010000);

        // Consumer back-pressure
        ready_mode = 2;
        send_price(120 << 8);
        for (int n = 0; n < 40 && !o_sum_valid; n++) @(negedge i_clk);
        for (int n = 0; n < 10; n++) begin
            @(negedge i_clk);
            chk("hold_valid", o_sum_valid, 1);
            chk("hold_ready_low", o_price_ready, 0);
            if (exp_q.size() != 0) begin
                chk("hold_gain", o_gain_sum, exp_q[0][EW-1 -: 32]);
                chk("hold_loss", o_loss_sum, exp_q[0][FW+31 -: 32]);
            end
        end
        ready_mode = 0;
        wait_done();

        // Flush while waiting for the adder
        send_price(130 << 8);
        repeat (3) tick();
        do_flush(0);
        n_before = n_res;
        send_price(50 << 8);
        send_price(49 << 8);
        wait_done();
`ifdef RSI_SCHED_WARMUP_EN
        chk("flush_no_result", n_res, n_before);
`else
        chk("flush_n_res", n_res, n_before + 1);
        chk("flush_gain", last_g, 0);
        chk("flush_loss", last_l, 32'h00010000);
        chk("flush_fill", last_f, 1);
`endif

        // Flush wins over a simultaneous price
        do_flush(1);
        send_price(60 << 8);
        send_price(61 << 8);
        wait_done();

        // Reset during ISSUE_L
        send_price(62 << 8);
        tick();
        i_rst = 1'b1;
        model_clear();
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_sum_valid", o_sum_valid, 0);
        chk("mid_rst_fill", o_fill, 0);
        chk("mid_rst_price_ready", o_price_ready, 1);
        tick();
        n_before = n_res;
        send_price(70 << 8);
        repeat (12) tick();
        chk("prev_only_after_rst", n_res, n_before);
        send_price(71 << 8);
        wait_done();

        // Randomized phase
        for (int it = 0; it < 250; it++) begin
            ready_mode = $urandom_range(0, 1);
            repeat ($urandom_range(0, 8)) tick();
            if ($urandom_range(0, 39) == 0)
                do_flush(1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 1) == 0)
                send_price($urandom_range(0, 65535));
            else
                send_price((m_prev + $urandom_range(0, 1024) - 512) & 16'hFFFF);
        end
        ready_mode = 0;
        wait_done();
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
